// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship monster spawner: state and lane encodings,
// difficulty tables and the LFSR step function shared by every random source.
package nexys_starship_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        COOL = 4'b0010,
        ROLL = 4'b0100,
        REQ  = 4'b1000
    } state_t;

    localparam logic [1:0] LANE_TOP    = 2'd0;
    localparam logic [1:0] LANE_BOTTOM = 2'd1;
    localparam logic [1:0] LANE_LEFT   = 2'd2;
    localparam logic [1:0] LANE_RIGHT  = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Spawn probability per tick is thresh/1024, rising with difficulty.
    function automatic logic [9:0] thresh_of(input logic [1:0] difficulty);
        logic [9:0] t;
        case (difficulty)
            2'd0:    t = 10'd1;
            2'd1:    t = 10'd4;
            2'd2:    t = 10'd16;
            2'd3:    t = 10'd64;
            default: t = 10'd64;
        endcase
        return t;
    endfunction

    function automatic logic [3:0] cool_of(input logic [1:0] difficulty);
        logic [3:0] c;
        case (difficulty)
            2'd0:    c = 4'd8;
            2'd1:    c = 4'd6;
            2'd2:    c = 4'd4;
            2'd3:    c = 4'd2;
            default: c = 4'd2;
        endcase
        return c;
    endfunction

    // Galois right-shift step; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Galois LFSR, advancing on every clock after reset.
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // LFSR state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/nexys_starship_spawner.sv
// Pseudo-random monster spawner feeding the quadrant monster stages via req/ack.
// Optional build macro NEXYS_SPAWN_FORCE_EN adds a force_spawn input.
module nexys_starship_spawner
    import nexys_starship_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic [1:0] difficulty,
    input  logic       spawn_ack,
`ifdef NEXYS_SPAWN_FORCE_EN
    input  logic       force_spawn,
`endif
    output logic       spawn_req,
    output logic [1:0] spawn_lane,
    output logic [7:0] spawn_count,
    output logic       q_Idle,
    output logic       q_Cool,
    output logic       q_Roll,
    output logic       q_Req
);

    localparam int unsigned    PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRE_ONE  = PW'(1);
    localparam logic [PW-1:0]  PRE_ZERO = PW'(0);

    state_t        r_state;
    logic [PW-1:0] r_prescaler;
    logic [3:0]    r_cool_cnt;
    logic          r_spawn_req;
    logic [1:0]    r_spawn_lane;
    logic [7:0]    r_spawn_count;

    state_t        w_state_nxt;
    logic [PW-1:0] w_pre_nxt;
    logic [3:0]    w_cool_nxt;
    logic          w_req_nxt;
    logic [1:0]    w_lane_nxt;
    logic [7:0]    w_count_nxt;

    logic [15:0]   w_lfsr;
    logic [3:0]    w_unused_lfsr;
    logic          w_tick;
    logic          w_hit;
    logic          w_force;

    nexys_starship_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .Clk     (Clk),
        .Reset   (Reset),
        .o_state (w_lfsr)
    );

    assign w_unused_lfsr = w_lfsr[15:12];

`ifdef NEXYS_SPAWN_FORCE_EN
    assign w_force = force_spawn;
`else
    assign w_force = 1'b0;
`endif

    assign w_tick = (r_state != IDLE) && (r_prescaler == PRE_MAX);
    assign w_hit  = (w_lfsr[9:0] < thresh_of(difficulty));

    // Next-state and next-output decode for the spawner FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cool_nxt  = r_cool_cnt;
        w_req_nxt   = r_spawn_req;
        w_lane_nxt  = r_spawn_lane;
        w_count_nxt = r_spawn_count;
        if ((r_state == IDLE) || w_tick) begin
            w_pre_nxt = PRE_ZERO;
        end else begin
            w_pre_nxt = r_prescaler + PRE_ONE;
        end

        if (!play_flag) begin
            // Leaving play drops any pending request uncounted; the count survives.
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
            w_pre_nxt   = PRE_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = COOL;
                    w_cool_nxt  = cool_of(difficulty);
                end
                COOL: begin
                    if (w_force) begin
                        w_state_nxt = REQ;
                        w_req_nxt   = 1'b1;
                        w_lane_nxt  = w_lfsr[11:10];
                    end else if (w_tick) begin
                        if (r_cool_cnt == 4'd1) begin
                            w_state_nxt = ROLL;
                        end else begin
                            w_cool_nxt = r_cool_cnt - 4'd1;
                        end
                    end else begin
                        w_state_nxt = COOL;
                    end
                end
                ROLL: begin
                    if (w_force || (w_tick && w_hit)) begin
                        w_state_nxt = REQ;
                        w_req_nxt   = 1'b1;
                        w_lane_nxt  = w_lfsr[11:10];
                    end else begin
                        w_state_nxt = ROLL;
                    end
                end
                REQ: begin
                    if (spawn_ack) begin
                        w_state_nxt = COOL;
                        w_req_nxt   = 1'b0;
                        w_cool_nxt  = cool_of(difficulty);
                        w_count_nxt = (r_spawn_count == 8'hFF) ? 8'hFF
                                                               : r_spawn_count + 8'd1;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_req_nxt   = 1'b0;
                    w_pre_nxt   = PRE_ZERO;
                end
            endcase
        end
    end

    // All spawner state and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_prescaler   <= PRE_ZERO;
            r_cool_cnt    <= 4'd0;
            r_spawn_req   <= 1'b0;
            r_spawn_lane  <= LANE_TOP;
            r_spawn_count <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_prescaler   <= w_pre_nxt;
            r_cool_cnt    <= w_cool_nxt;
            r_spawn_req   <= w_req_nxt;
            r_spawn_lane  <= w_lane_nxt;
            r_spawn_count <= w_count_nxt;
        end
    end

    assign spawn_req   = r_spawn_req;
    assign spawn_lane  = r_spawn_lane;
    assign spawn_count = r_spawn_count;
    assign q_Idle      = r_state[0];
    assign q_Cool      = r_state[1];
    assign q_Roll      = r_state[2];
    assign q_Req       = r_state[3];

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// Self-checking bench for nexys_starship_spawner: directed stimulus, a
// behavioural model checked every cycle, and hand-computed pin values.
module tb_nexys_starship_spawner;

    localparam int TD = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       play_flag = 1'b0;
    logic [1:0] difficulty = 2'd0;
    logic       spawn_ack = 1'b0;
`ifdef NEXYS_SPAWN_FORCE_EN
    logic       force_spawn = 1'b0;
`endif
    logic       spawn_req;
    logic [1:0] spawn_lane;
    logic [7:0] spawn_count;
    logic       q_Idle, q_Cool, q_Roll, q_Req;

    int checks = 0;
    int errors = 0;

    // Model: mode 0=idle 1=cool 2=roll 3=req; m_run = clocks spent out of idle.
    int          m_mode, m_cool, m_run, m_count, m_lane;
    bit          m_req;
    logic [15:0] m_lfsr;

    nexys_starship_spawner #(.TICK_DIV(TD), .SEED(16'hACE1)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .play_flag   (play_flag),
        .difficulty  (difficulty),
        .spawn_ack   (spawn_ack),
`ifdef NEXYS_SPAWN_FORCE_EN
        .force_spawn (force_spawn),
`endif
        .spawn_req   (spawn_req),
        .spawn_lane  (spawn_lane),
        .spawn_count (spawn_count),
        .q_Idle      (q_Idle),
        .q_Cool      (q_Cool),
        .q_Roll      (q_Roll),
        .q_Req       (q_Req)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int thr(input int d);
        return 1 << (2 * d);
    endfunction

    function automatic int cool_ticks(input int d);
        return 8 - 2 * d;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cool = 0; m_run = 0; m_count = 0; m_lane = 0;
        m_req = 1'b0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_step();
        int nxt;
        bit tick, hit, frc;
        frc = 1'b0;
`ifdef NEXYS_SPAWN_FORCE_EN
        frc = force_spawn;
`endif
        tick = (m_mode != 0) && ((m_run % TD) == TD - 1);
        hit  = (int'(m_lfsr & 16'h03FF) < thr(int'(difficulty)));
        nxt  = m_mode;
        if (!play_flag) begin
            nxt = 0; m_req = 1'b0;
        end else if (m_mode == 0) begin
            nxt = 1; m_cool = cool_ticks(int'(difficulty));
        end else if (frc && (m_mode == 1 || m_mode == 2)) begin
            nxt = 3; m_req = 1'b1; m_lane = int'(m_lfsr[11:10]);
        end else if (m_mode == 1 && tick) begin
            if (m_cool == 1) nxt = 2;
            else m_cool = m_cool - 1;
        end else if (m_mode == 2 && tick && hit) begin
            nxt = 3; m_req = 1'b1; m_lane = int'(m_lfsr[11:10]);
        end else if (m_mode == 3 && spawn_ack) begin
            nxt = 1; m_req = 1'b0; m_cool = cool_ticks(int'(difficulty));
            if (m_count < 255) m_count = m_count + 1;
        end
        m_run  = (m_mode != 0 && nxt != 0) ? m_run + 1 : 0;
        m_mode = nxt;
        m_lfsr = galois(m_lfsr);
    endtask

    // Compare process: DUT outputs versus model on every falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge Clk);
            if (Reset) model_reset();
            chk("state", {28'd0, q_Req, q_Roll, q_Cool, q_Idle}, 32'd1 << m_mode);
            chk("spawn_req", spawn_req, m_req);
            if (m_req) chk("spawn_lane", spawn_lane, m_lane);
            chk("spawn_count", spawn_count, m_count);
            chk("lfsr", dut.u_lfsr.o_state, m_lfsr);
            chk("req_in_idle_cool", spawn_req & (q_Idle | q_Cool), 1'b0);
            if (!Reset) model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_req(input int limit);
        int n;
        n = 0;
        while (!spawn_req && n < limit) begin
            cyc(1);
            n++;
        end
        chk("wait_req_timeout", spawn_req, 1'b1);
    endtask

    initial begin
        int n;
        logic [1:0] lane0;
        #1 Reset = 1'b1;
        cyc(3);
        chk("rst_req", spawn_req, 1'b0);
        chk("rst_lane", spawn_lane, 2'd0);
        chk("rst_count", spawn_count, 8'd0);
        chk("rst_state", {q_Req, q_Roll, q_Cool, q_Idle}, 4'b0001);
        chk("rst_lfsr", dut.u_lfsr.o_state, 16'hACE1);
        Reset = 1'b0;
        cyc(1); chk("lfsr_1", dut.u_lfsr.o_state, 16'hE270);
        cyc(1); chk("lfsr_2", dut.u_lfsr.o_state, 16'h7138);
        cyc(1); chk("lfsr_3", dut.u_lfsr.o_state, 16'h389C);
        cyc(1); chk("lfsr_4", dut.u_lfsr.o_state, 16'h1C4E);
        cyc(1); chk("lfsr_5", dut.u_lfsr.o_state, 16'h0E27);
        cyc(1); chk("lfsr_6", dut.u_lfsr.o_state, 16'hB313);
        cyc(58);

        // Hard difficulty: two ticks of cooldown, i.e. eight clocks.
        difficulty = 2'd3;
        play_flag  = 1'b1;
        cyc(1);
        n = 0;
        while (q_Cool && n < 20) begin
            n++;
            cyc(1);
        end
        chk("cool_clocks", n, 8);
        chk("roll_after_cool", q_Roll, 1'b1);

        wait_req(4000);
        lane0 = spawn_lane;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("hold_req", spawn_req, 1'b1);
            chk("hold_lane", spawn_lane, lane0);
        end
        spawn_ack = 1'b1;
        cyc(1);
        spawn_ack = 1'b0;
        chk("ack_req", spawn_req, 1'b0);
        chk("ack_count", spawn_count, 8'd1);
        chk("ack_cool", q_Cool, 1'b1);

        // play_flag drop beats a simultaneous ack.
        wait_req(4000);
        play_flag = 1'b0;
        spawn_ack = 1'b1;
        cyc(1);
        chk("drop_idle", q_Idle, 1'b1);
        chk("drop_req", spawn_req, 1'b0);
        chk("drop_count", spawn_count, 8'd1);
        spawn_ack = 1'b0;
        cyc(3);

        // Ack tied high: 300 accepted spawns saturate the counter.
        play_flag  = 1'b1;
        spawn_ack  = 1'b1;
        difficulty = 2'd2;
        for (int i = 0; i < 300; i++) begin
            if (i == 10) difficulty = 2'd3;
            wait_req(8000);
            cyc(1);
        end
        chk("sat_count", spawn_count, 8'd255);
        cyc(5);

        // Asynchronous reset while a request is pending.
        spawn_ack = 1'b0;
        wait_req(4000);
        #2 Reset = 1'b1;
        #1;
        chk("rst_async_req", spawn_req, 1'b0);
        chk("rst_async_idle", q_Idle, 1'b1);
        chk("rst_async_count", spawn_count, 8'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        cyc(3);

`ifdef NEXYS_SPAWN_FORCE_EN
        difficulty = 2'd0;
        cyc(2);
        chk("force_in_cool", q_Cool, 1'b1);
        force_spawn = 1'b1;
        cyc(1);
        force_spawn = 1'b0;
        chk("force_req", spawn_req, 1'b1);
        chk("force_state", q_Req, 1'b1);
        cyc(2);
`endif

        play_flag = 1'b0;
        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
